// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between two
// requesters; each operation runs IDLE -> EXEC -> RESP.
module alu_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [WIDTH-1:0] resp0_result,
   output logic [WIDTH-1:0] resp0_overflow,
   output logic             resp0_err,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp1_result,
   output logic [WIDTH-1:0] resp1_overflow,
   output logic             resp1_err,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_overflow,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic             ptr;
   logic             src;
   logic             grant;
   logic             bad;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [2:0]       opc;

   // With a single valid requester the pointer is ignored.
   always_comb begin
      if (req0_valid && req1_valid) grant = ptr;
      else                          grant = req1_valid;
   end

   assign req0_ready = (state == IDLE) && !grant && req0_valid;
   assign req1_ready = (state == IDLE) &&  grant && req1_valid;
   assign busy       = (state != IDLE);
   assign alu_a      = opa;
   assign alu_b      = opb;
   assign alu_ctrl   = opc;
   assign bad        = (opc[2:1] == 2'b11) || ((opc == 3'b011) && (opb == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ptr            <= 1'b0;
         src            <= 1'b0;
         opa            <= '0;
         opb            <= '0;
         opc            <= '0;
         resp0_valid    <= 1'b0;
         resp0_result   <= '0;
         resp0_overflow <= '0;
         resp0_err      <= 1'b0;
         resp1_valid    <= 1'b0;
         resp1_result   <= '0;
         resp1_overflow <= '0;
         resp1_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready) begin
                  opa   <= req0_a;
                  opb   <= req0_b;
                  opc   <= req0_op;
                  src   <= 1'b0;
                  state <= EXEC;
               end else if (req1_ready) begin
                  opa   <= req1_a;
                  opb   <= req1_b;
                  opc   <= req1_op;
                  src   <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (!src) begin
                  resp0_valid    <= 1'b1;
                  resp0_result   <= bad ? '0 : alu_result;
                  resp0_overflow <= bad ? '0 : alu_overflow;
                  resp0_err      <= bad;
               end else begin
                  resp1_valid    <= 1'b1;
                  resp1_result   <= bad ? '0 : alu_result;
                  resp1_overflow <= bad ? '0 : alu_overflow;
                  resp1_err      <= bad;
               end
               state <= RESP;
            end
            RESP: begin
               if (!src && resp0_ready) begin
                  resp0_valid <= 1'b0;
                  ptr         <= 1'b1;
                  state       <= IDLE;
               end else if (src && resp1_ready) begin
                  resp1_valid <= 1'b0;
                  ptr         <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]  req0_op = '0, req1_op = '0;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [15:0] resp0_result, resp0_overflow, resp1_result, resp1_overflow;
   logic        resp0_err, resp1_err;
   logic [15:0] alu_a, alu_b, alu_result, alu_overflow;
   logic [2:0]  alu_ctrl;
   logic        busy;

   typedef struct {
      bit          src;
      logic [15:0] res;
      logic [15:0] ovf;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   alu_arbiter #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
      .resp0_overflow(resp0_overflow), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
      .resp1_overflow(resp1_overflow), .resp1_err(resp1_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_overflow(alu_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // ALU stand-in: illegal/div-zero cases return recognisable garbage.
   logic [31:0] prod;
   always_comb begin
      prod         = 32'(alu_a) * 32'(alu_b);
      alu_result   = '0;
      alu_overflow = '0;
      case (alu_ctrl)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = alu_a - alu_b;
         3'b010: begin alu_result = prod[15:0]; alu_overflow = prod[31:16]; end
         3'b011: begin
            if (alu_b != 16'd0) begin
               alu_result   = alu_a / alu_b;
               alu_overflow = alu_a % alu_b;
            end else begin
               alu_result   = 16'hDEAD;
               alu_overflow = 16'hBEEF;
            end
         end
         3'b100: alu_result = alu_a & alu_b;
         3'b101: alu_result = alu_a | alu_b;
         default: begin alu_result = 16'hDEAD; alu_overflow = 16'hBEEF; end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t calc(input bit n, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op);
      exp_t        e;
      logic [31:0] p;
      e.src = n; e.res = 16'h0000; e.ovf = 16'h0000; e.err = 1'b0;
      p = {16'h0000, a} * {16'h0000, b};
      case (op)
         3'd0: e.res = a + b;
         3'd1: e.res = a - b;
         3'd2: begin e.res = p[15:0]; e.ovf = p[31:16]; end
         3'd3: if (b == 16'h0000) e.err = 1'b1;
               else begin e.res = a / b; e.ovf = a % b; end
         3'd4: e.res = a & b;
         3'd5: e.res = a | b;
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic rv(input bit n);
      return n ? resp1_valid : resp0_valid;
   endfunction
   function automatic logic [15:0] rres(input bit n);
      return n ? resp1_result : resp0_result;
   endfunction
   function automatic logic [15:0] rovf(input bit n);
      return n ? resp1_overflow : resp0_overflow;
   endfunction
   function automatic logic rerr(input bit n);
      return n ? resp1_err : resp0_err;
   endfunction

   task automatic set_req(input bit n, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op);
      if (n) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
      else   begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
   endtask

   task automatic issue(input bit n, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      bit got = 1'b0;
      @(negedge clk);
      set_req(n, 1'b1, a, b, op);
      for (int unsigned i = 0; i < 20 && !got; i++) begin
         #1;
         got = n ? req1_ready : req0_ready;
         if (!got) @(negedge clk);
      end
      chk("issue_ready", got, 1);
      if (got) begin
         chk("issue_other_ready", n ? req0_ready : req1_ready, 0);
         sb.push_back(calc(n, a, b, op));
         @(posedge clk); #1;
         chk("alu_a", alu_a, a);
         chk("alu_b", alu_b, b);
         chk("alu_ctrl", alu_ctrl, op);
         chk("busy_exec", busy, 1);
      end
      if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_resp(input bit n, input int unsigned hold, input bit pulse);
      int unsigned waited = 0;
      bit          seen = 1'b0;
      exp_t        e;
      logic [15:0] r, o;
      logic        er;
      if (n) resp1_ready = (hold == 0); else resp0_ready = (hold == 0);
      for (int unsigned i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         waited++;
         seen = rv(n);
      end
      chk("resp_seen", seen, 1);
      if (!seen) return;
      chk("resp_latency", waited, 2);
      chk("other_resp_valid", rv(!n), 0);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      r = rres(n); o = rovf(n); er = rerr(n);
      chk("resp_src", n, e.src);
      chk("resp_result", r, e.res);
      chk("resp_overflow", o, e.ovf);
      chk("resp_err", er, e.err);
      for (int unsigned i = 0; i < hold; i++) begin
         @(negedge clk);
         if (pulse && i == 1) begin
            if (n) req0_valid = 1'b0; else req1_valid = 1'b0;
         end
         #1;
         if (pulse && i == 0) begin
            if (n) req0_valid = 1'b1; else req1_valid = 1'b1;
            #1;
         end
         chk("hold_valid", rv(n), 1);
         chk("hold_result", rres(n), r);
         chk("hold_overflow", rovf(n), o);
         chk("hold_err", rerr(n), er);
         chk("hold_no_ready", {req0_ready, req1_ready}, 2'b00);
      end
      if (n) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(posedge clk); #1;
      chk("consumed_valid", rv(n), 0);
      chk("consumed_busy", busy, 0);
      if (n) resp1_ready = 1'b0; else resp0_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit order[4];
      bit g;
      bit got;
      order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0; order[3] = 1'b1;

      // Reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
      chk("rst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
      chk("rst_resp0_data", {resp0_result, resp0_overflow}, 32'h0);
      chk("rst_err", {resp0_err, resp1_err}, 2'b00);
      chk("rst_alu", {alu_a, alu_b, 13'(alu_ctrl)}, 45'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Wrap-around add; req0 completion moves the pointer to req1
      issue(0, 16'hFFFF, 16'h0001, 3'b000);
      wait_resp(0, 0, 0);

      // Reset mid-EXEC discards the operation
      @(negedge clk);
      set_req(0, 1'b1, 16'h0005, 16'h0006, 3'b000);
      #1;
      chk("pre_rst_ready", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      chk("pre_rst_busy", busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", {req0_ready, req1_ready}, 2'b00);
      chk("mid_rst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
      chk("mid_rst_alu_ctrl", alu_ctrl, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_no_resp", {resp0_valid, resp1_valid, busy}, 3'b000);

      // First contention after reset goes to req0
      set_req(0, 1'b1, 16'h0010, 16'h0020, 3'b000);
      set_req(1, 1'b1, 16'h0001, 16'h0001, 3'b001);
      #1;
      chk("contend_grant", {req0_ready, req1_ready}, 2'b10);
      sb.push_back(calc(0, 16'h0010, 16'h0020, 3'b000));
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_resp(0, 0, 0);

      // Single add
      issue(0, 16'h0003, 16'h0004, 3'b000);
      wait_resp(0, 0, 0);

      // Multiply and divide on req1
      issue(1, 16'h1234, 16'h0100, 3'b010);
      wait_resp(1, 0, 0);
      issue(1, 16'd100, 16'd7, 3'b011);
      wait_resp(1, 0, 0);

      // Error cases, then a legal op (underflowing sub)
      issue(0, 16'h1234, 16'h0000, 3'b011);
      wait_resp(0, 0, 0);
      issue(0, 16'h0001, 16'h0002, 3'b110);
      wait_resp(0, 0, 0);
      issue(0, 16'h0001, 16'h0002, 3'b111);
      wait_resp(0, 0, 0);
      issue(1, 16'h0000, 16'h0001, 3'b001);
      wait_resp(1, 0, 0);

      // Round-robin with both requesters continuously valid
      set_req(0, 1'b1, 16'h00F0, 16'h0F0F, 3'b100);
      set_req(1, 1'b1, 16'h0300, 16'h0003, 3'b010);
      for (int unsigned k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int unsigned i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            got = req0_ready | req1_ready;
         end
         chk("rr_handshake", got, 1);
         chk("rr_one_ready", req0_ready & req1_ready, 0);
         g = req1_ready;
         chk("rr_grant", g, order[k]);
         if (g) sb.push_back(calc(1, req1_a, req1_b, req1_op));
         else   sb.push_back(calc(0, req0_a, req0_b, req0_op));
         @(posedge clk); #1;
         if (g) begin req1_a = req1_a + 16'h0111; req1_op = 3'b011; end
         else   begin req0_a = req0_a + 16'h1000; req0_op = 3'b101; end
         wait_resp(g, 3, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // req1 valid pulses during RESP and is withdrawn
      issue(0, 16'h00F0, 16'h0F00, 3'b101);
      wait_resp(0, 3, 1);
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("withdraw_idle", {busy, req1_ready, resp1_valid}, 3'b000);
      end
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
